// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: one shared BCD decoder, per-digit on/blank timing,
// shadowed value capture committed only at frame boundaries.
//
// state      | meaning
// IDLE       | display dark, waiting for enable
// SCAN_ON    | digit idx driven for ON_CYCLES cycles
// SCAN_BLANK | all digits off for BLANK_CYCLES cycles before the next digit
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int ON_CYCLES    = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int IW      = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] ON_M1    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_M1 = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST     = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SCAN_ON, SCAN_BLANK} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [4*NUM_DIGITS-1:0] disp, disp_nxt;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nxt;
  logic                    pending_nxt;
  logic                    commit;
  logic                    suppress;
  logic [3:0]              cur_digit;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   dig_en_nxt;
  logic                    frame_done_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1111110;
      4'd1:    seg_decode = 7'b0110000;
      4'd2:    seg_decode = 7'b1101101;
      4'd3:    seg_decode = 7'b1111001;
      4'd4:    seg_decode = 7'b0110011;
      4'd5:    seg_decode = 7'b1011011;
      4'd6:    seg_decode = 7'b1011111;
      4'd7:    seg_decode = 7'b1110000;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1111011;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    cnt_nxt        = cnt;
    commit         = 1'b0;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = SCAN_ON;
          idx_nxt   = '0;
          cnt_nxt   = ON_M1;
          commit    = 1'b1;
        end
      end
      SCAN_ON: begin
        if (cnt == '0) begin
          state_nxt = SCAN_BLANK;
          cnt_nxt   = BLANK_M1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      SCAN_BLANK: begin
        if (cnt == '0) begin
          state_nxt = SCAN_ON;
          cnt_nxt   = ON_M1;
          if (idx == LAST) begin
            idx_nxt        = '0;
            commit         = 1'b1;
            frame_done_nxt = 1'b1;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) begin
      state_nxt      = IDLE;
      idx_nxt        = '0;
      cnt_nxt        = '0;
      commit         = 1'b0;
      frame_done_nxt = 1'b0;
    end

    // Commit uses the shadow as it stood before any coincident load.
    disp_nxt    = (commit && pending) ? shadow : disp;
    shadow_nxt  = load ? value : shadow;
    pending_nxt = load ? 1'b1 : (commit ? 1'b0 : pending);

    // Outputs are registered, so they are derived from the next-cycle state and display.
    cur_digit  = 4'(disp_nxt >> (4 * idx_nxt));
    suppress   = blank_lz && (idx_nxt != '0) && ((disp_nxt >> (4 * idx_nxt)) == '0);
    seg_nxt    = '0;
    dig_en_nxt = '0;
    if (state_nxt == SCAN_ON) begin
      dig_en_nxt = NUM_DIGITS'(1) << idx_nxt;
      if (!suppress) seg_nxt = seg_decode(cur_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      disp       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      seg        <= '0;
      dig_en     <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      disp       <= disp_nxt;
      shadow     <= shadow_nxt;
      pending    <= pending_nxt;
      seg        <= seg_nxt;
      dig_en     <= dig_en_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: time-position reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seven_seg_scan_ctrl;
  localparam int N  = 4;
  localparam int ON = 4;
  localparam int BL = 1;
  localparam int SLOT = ON + BL;
  localparam int P  = N * SLOT;

  logic clk = 1'b0;
  logic rst, enable, load, blank_lz;
  logic [4*N-1:0] value;
  logic [6:0] seg;
  logic [N-1:0] dig_en;
  logic pending, frame_done;

  int checks = 0;
  int errors = 0;

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .value(value),
    .blank_lz(blank_lz), .seg(seg), .dig_en(dig_en), .pending(pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  logic [6:0] dec [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1111111, 7'b1111111,
                           7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};

  // Model: t counts cycles since the scan started; everything follows from t mod frame.
  bit            m_run = 1'b0;
  bit            m_valid = 1'b0;
  int            m_t = 0;
  logic [4*N-1:0] m_disp = '0, m_shad = '0;
  bit            m_pend = 1'b0;
  logic [6:0]    e_seg;
  logic [N-1:0]  e_dig;
  bit            e_fd;

  always @(posedge clk) begin
    int ph, d;
    bit commit;
    if (rst) begin
      m_run = 0; m_t = 0; m_disp = '0; m_shad = '0; m_pend = 0;
    end else begin
      commit = enable && (!m_run || ((m_t + 1) % P == 0));
      if (commit && m_pend) begin m_disp = m_shad; m_pend = 0; end
      if (load) begin m_shad = value; m_pend = 1; end
      if (!enable) begin m_run = 0; m_t = 0; end
      else if (!m_run) begin m_run = 1; m_t = 0; end
      else m_t = m_t + 1;
    end
    e_seg = '0; e_dig = '0; e_fd = 0;
    if (m_run) begin
      ph = m_t % P;
      d  = ph / SLOT;
      if (ph % SLOT < ON) begin
        e_dig = N'(1) << d;
        if (!(blank_lz && d > 0 && (m_disp >> (4 * d)) == 0))
          e_seg = dec[(m_disp >> (4 * d)) & 15];
      end
      e_fd = (m_t > 0) && (ph == 0);
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if ({seg, dig_en, pending, frame_done} !== {e_seg, e_dig, m_pend, e_fd}) begin
        errors++;
        $display("FAIL model t=%0d: seg=%b dig_en=%b pending=%b fd=%b, required seg=%b dig_en=%b pending=%b fd=%b",
                 m_t, seg, dig_en, pending, frame_done, e_seg, e_dig, m_pend, e_fd);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1; enable = 0; load = 0; value = '0; blank_lz = 0;
    step(); step();
    rst = 0; step();
    chk("reset_outputs", {seg, dig_en, pending, frame_done}, '0);

    value = 16'h1234; load = 1; step(); load = 0;
    chk("pending_after_load", pending, 1);
    enable = 1; step();                                   // t=0
    chk("d0_seg_1234", {dig_en, seg}, {4'b0001, 7'b0110011});
    chk("pending_cleared_idle_exit", pending, 0);
    run(4);                                               // t=4
    chk("blank_gap", {dig_en, seg}, '0);
    run(1);                                               // t=5
    chk("d1_seg_1234", {dig_en, seg}, {4'b0010, 7'b1111001});
    run(15);                                              // t=20
    chk("wrap_frame_done", {frame_done, dig_en, seg}, {1'b1, 4'b0001, 7'b0110011});

    value = 16'h5678; load = 1; step(); load = 0;         // t=21
    chk("midframe_pending", {pending, seg}, {1'b1, 7'b0110011});
    run(4);                                               // t=25
    chk("midframe_no_tear", {dig_en, seg}, {4'b0010, 7'b1111001});
    run(15);                                              // t=40
    chk("commit_5678_d0", {pending, dig_en, seg}, {1'b0, 4'b0001, 7'b1111111});

    blank_lz = 1; value = 16'h0070; load = 1; step(); load = 0;  // t=41
    run(19);                                              // t=60
    chk("lz_0070_d0", {dig_en, seg}, {4'b0001, 7'b1111110});
    run(5);                                               // t=65
    chk("lz_0070_d1", {dig_en, seg}, {4'b0010, 7'b1110000});
    run(5);                                               // t=70
    chk("lz_0070_d2_dark", {dig_en, seg}, {4'b0100, 7'b0000000});

    value = 16'h0000; load = 1; step(); load = 0;         // t=71
    run(9);                                               // t=80
    chk("lz_0000_d0", {dig_en, seg}, {4'b0001, 7'b1111110});
    run(5);                                               // t=85
    chk("lz_0000_d1_dark", {dig_en, seg}, {4'b0010, 7'b0000000});

    value = 16'h00C0; load = 1; step(); load = 0;         // t=86
    run(14);                                              // t=100
    chk("lz_00c0_d0", {dig_en, seg}, {4'b0001, 7'b1111110});
    run(5);                                               // t=105
    chk("lz_00c0_d1_lit", {dig_en, seg}, {4'b0010, 7'b1111111});

    blank_lz = 0; value = 16'h000C; load = 1; step(); load = 0;  // t=106
    run(14);                                              // t=120
    chk("code_c_d0", {dig_en, seg}, {4'b0001, 7'b1111111});
    run(10);                                              // t=130
    chk("on_digit2", dig_en, 4'b0100);

    enable = 0; step();
    chk("disable_dark", {dig_en, seg, frame_done}, '0);
    value = 16'h4321; load = 1; step(); load = 0;
    chk("idle_load_pending", pending, 1);
    enable = 1; step();
    chk("reenable_commit", {pending, dig_en, seg}, {1'b0, 4'b0001, 7'b0110000});

    run(7);
    rst = 1; value = 16'hFFFF; load = 1; step();
    chk("rst_over_load", {seg, dig_en, pending, frame_done}, '0);
    rst = 0; load = 0; step();
    chk("rst_cleared_shadow", {pending, dig_en, seg}, {1'b0, 4'b0001, 7'b1111110});

    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
      load = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 2))
        0:       value = 16'($urandom);
        1:       value = 16'($urandom) & 16'h00FF;
        default: value = 16'($urandom) & 16'h000F;
      endcase
      step();
    end

    rst = 0; load = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
